// File: rtl/mem_loader_if.sv
// Byte-stream input, RAM write port and status bundle for mem_loader.
// The loader side uses the slave modport; the stream source / controller side uses master.
interface mem_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    logic                  busy;
    logic                  done;
    logic                  csum_err;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, we, a, d, busy, done, csum_err
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, we, a, d, busy, done, csum_err
    );
endinterface

// File: rtl/mem_loader.sv
// Assembles a byte stream (high byte first) into 16-bit words and writes them to RAM.
// Define MEM_LOADER_CHECKSUM_EN to require a trailing 16-bit sum word after the image.
module mem_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int WORD_COUNT = 784,
    parameter int BASE_ADDR  = 0
) (
    input logic         clk,
    input logic         rst_n,
    mem_loader_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    // Counter is one bit wider than the address so a full 2^ADDR_WIDTH load is reachable.
    localparam logic [ADDR_WIDTH:0]   LAST     = (ADDR_WIDTH+1)'(WORD_COUNT);

`ifdef MEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE, CK_HI, CK_LO} state_t;
`else
    typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;
`endif

    state_t                state;
    logic                  inReady;
    logic                  weQ;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  busyQ;
    logic                  doneQ;
    logic                  csumErr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   countNext;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [15:0]           sum;
    logic [7:0]            ckHi;
`endif

    assign countNext    = count + CNT_ONE;
    assign bus.in_ready = inReady;
    assign bus.we       = weQ;
    assign bus.a        = addr;
    assign bus.d        = data;
    assign bus.busy     = busyQ;
    assign bus.done     = doneQ;
    assign bus.csum_err = csumErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            inReady <= 1'b0;
            weQ     <= 1'b0;
            addr    <= BASE;
            data    <= '0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
            csumErr <= 1'b0;
            count   <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum     <= '0;
            ckHi    <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    // in_ready is low here, so a byte offered alongside start is left with the source.
                    if (bus.start) begin
                        state   <= HI;
                        inReady <= 1'b1;
                        busyQ   <= 1'b1;
                        doneQ   <= 1'b0;
                        csumErr <= 1'b0;
                        count   <= '0;
                        addr    <= BASE;
`ifdef MEM_LOADER_CHECKSUM_EN
                        sum     <= '0;
`endif
                    end
                end
                HI: begin
                    if (bus.in_valid) begin
                        data[15:8] <= bus.in_data;
                        state      <= LO;
                    end
                end
                LO: begin
                    if (bus.in_valid) begin
                        data[7:0] <= bus.in_data;
                        inReady   <= 1'b0;
                        weQ       <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    weQ   <= 1'b0;
                    addr  <= addr + ADDR_ONE;
                    count <= countNext;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum   <= sum + data[15:0];
`endif
                    if (countNext == LAST) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                        state   <= CK_HI;
                        inReady <= 1'b1;
`else
                        state   <= DONE;
                        busyQ   <= 1'b0;
                        doneQ   <= 1'b1;
`endif
                    end else begin
                        state   <= HI;
                        inReady <= 1'b1;
                    end
                end
`ifdef MEM_LOADER_CHECKSUM_EN
                CK_HI: begin
                    if (bus.in_valid) begin
                        ckHi  <= bus.in_data;
                        state <= CK_LO;
                    end
                end
                CK_LO: begin
                    // Trailer word is only compared, never written to RAM.
                    if (bus.in_valid) begin
                        csumErr <= ({ckHi, bus.in_data} != sum);
                        inReady <= 1'b0;
                        busyQ   <= 1'b0;
                        doneQ   <= 1'b1;
                        state   <= DONE;
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    inReady <= 1'b0;
                    weQ     <= 1'b0;
                    busyQ   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected RAM writes are queued as bytes are driven
// and popped when we pulses; we timing is modelled from observed byte transfers.
module tb_mem_loader;

    localparam int          AW   = 16;
    localparam int          WC   = 4;
    localparam logic [15:0] BASE = 16'h0010;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) bus ();

    mem_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(16),
        .WORD_COUNT(WC),
        .BASE_ADDR (16'h0010)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          vectors      = 0;
    int          miscompares  = 0;
    logic [31:0] expQ[$];
    int          acceptedBytes = 0;
    logic        pendingWe    = 1'b0;
    logic [15:0] loadWords[4];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Watches every cycle: we must follow a data low-byte transfer by exactly one cycle.
    task automatic monitorLoop();
        logic [31:0] e;
        logic        xfer;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("we_timing", 32'(bus.we), 32'(pendingWe));
                if (bus.we) begin
                    checkOutput("sb_pending", 32'(expQ.size() > 0), 32'd1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        checkOutput("write_addr", 32'(bus.a), 32'(e[31:16]));
                        checkOutput("write_data", 32'(bus.d), 32'(e[15:0]));
                    end
                end
                xfer      = bus.in_valid && bus.in_ready;
                pendingWe = xfer && (acceptedBytes < 2 * WC) && (acceptedBytes % 2 == 1);
                if (xfer) acceptedBytes++;
            end
        end
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gapPct);
        int cyc = 0;
        while ($urandom_range(99) < gapPct) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                break;
            end
            cyc++;
            if (cyc > 200) begin
                checkOutput("byte_timeout", 32'(cyc), 32'd0);
                bus.in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        checkOutput({tag, "_we"},       32'(bus.we),       32'd0);
        checkOutput({tag, "_a"},        32'(bus.a),        32'(BASE));
        checkOutput({tag, "_busy"},     32'(bus.busy),     32'd0);
        checkOutput({tag, "_done"},     32'(bus.done),     32'd0);
        checkOutput({tag, "_csum"},     32'(bus.csum_err), 32'd0);
    endtask

    task automatic runLoad(input int gapPct, input logic [15:0] delta,
                           input bit midStart, input bit lastStart);
        logic [15:0] sum = 16'h0000;
        logic [15:0] trailer;
        logic [15:0] w;
        logic        expErr = 1'b0;
        int          n = 0;
        acceptedBytes = 0;
        pulseStart();
        checkOutput("start_busy",  32'(bus.busy),     32'd1);
        checkOutput("start_done",  32'(bus.done),     32'd0);
        checkOutput("start_addr",  32'(bus.a),        32'(BASE));
        checkOutput("start_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("start_csum",  32'(bus.csum_err), 32'd0);
        for (int i = 0; i < WC; i++) begin
            w = loadWords[i];
            expQ.push_back({16'(BASE + 16'(i)), w});
            sum = sum + w;
            applyStimulus(w[15:8], gapPct);
            if (midStart && i == 1) pulseStart();
            applyStimulus(w[7:0], gapPct);
        end
        if (lastStart) pulseStart();
        trailer = sum + delta;
`ifdef MEM_LOADER_CHECKSUM_EN
        expErr = (delta != 16'h0000);
        applyStimulus(trailer[15:8], gapPct);
        applyStimulus(trailer[7:0], gapPct);
`endif
        while (!bus.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("done_wait", 32'(n < 100), 32'd1);
        checkOutput("end_busy",  32'(bus.busy),     32'd0);
        checkOutput("end_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("end_addr",  32'(bus.a),        32'(16'(BASE + 16'(WC))));
        checkOutput("end_csum",  32'(bus.csum_err), 32'(expErr));
        checkOutput("sb_empty",  32'(expQ.size()),  32'd0);
        if (lastStart) begin
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            checkOutput("late_start_done",  32'(bus.done),     32'd1);
            checkOutput("late_start_ready", 32'(bus.in_ready), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        fork
            monitorLoop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle with a byte on offer: nothing must be consumed or written.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkResetValues("idle");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;

        loadWords = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        runLoad(0, 16'h0000, 1'b0, 1'b0);

        loadWords = '{16'h0001, 16'h0002, 16'hFFFF, 16'h0000};
        runLoad(0, 16'h0000, 1'b0, 1'b0);
        runLoad(0, 16'h0001, 1'b0, 1'b0);

        loadWords = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        runLoad(50, 16'h0000, 1'b1, 1'b1);

        // Reset right after the second word is written.
        acceptedBytes = 0;
        pulseStart();
        for (int i = 0; i < 2; i++) begin
            expQ.push_back({16'(BASE + 16'(i)), loadWords[i]});
            applyStimulus(loadWords[i][15:8], 0);
            applyStimulus(loadWords[i][7:0], 0);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        expQ.delete();
        acceptedBytes = 0;
        pendingWe     = 1'b0;
        @(negedge clk);
        checkResetValues("rst");
        checkOutput("rst_d", 32'(bus.d), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        runLoad(30, 16'h0000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
